// File: rtl/motor_pwm_driver_if.sv
// Duty command and gate-drive bundle for motor_pwm_driver.
// master drives the command side; slave is the PWM stage.
interface motor_pwm_driver_if #(
  parameter int DUTY_WIDTH = 8
) ();
  logic [DUTY_WIDTH-1:0] MotorSignal;
  logic                  enable;
  logic                  fault;
  logic                  pwm_hi;
  logic                  pwm_lo;
  logic                  period_start;
  logic                  fault_latched;

  modport master (
    output MotorSignal,
    output enable,
    output fault,
    input  pwm_hi,
    input  pwm_lo,
    input  period_start,
    input  fault_latched
  );

  modport slave (
    input  MotorSignal,
    input  enable,
    input  fault,
    output pwm_hi,
    output pwm_lo,
    output period_start,
    output fault_latched
  );
endinterface

// File: rtl/motor_pwm_driver.sv
// Complementary PWM gate driver with dead time and latched fault.
// Optional PWM_SOFT_START_EN ramps duty up by one step per period.
module motor_pwm_driver #(
  parameter int DUTY_WIDTH = 8,
  parameter int DEAD_TIME  = 2
) (
  input logic               c20k,
  input logic               reset,
  motor_pwm_driver_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    DEAD_LH,
    HIGH,
    DEAD_HL,
    FAULT
  } state_e;

  localparam logic [DUTY_WIDTH-1:0] CNT_MAX =
    {{(DUTY_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [DUTY_WIDTH-1:0] ONE = 1;
  localparam logic [3:0] DT     = 4'(DEAD_TIME);
  localparam logic [3:0] DT_ONE = 4'd1;

  state_e                state_q, state_d;
  logic [DUTY_WIDTH-1:0] cnt_q, cnt_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d;
  logic [3:0]            dt_q, dt_d;
  logic                  hi_req;
  logic                  run_q, run_d;
  logic                  wrap;

  assign hi_req = cnt_q < duty_q;
  assign run_q  = state_q inside {LOW, DEAD_LH, HIGH, DEAD_HL};
  assign run_d  = state_d inside {LOW, DEAD_LH, HIGH, DEAD_HL};
  assign wrap   = run_q && run_d && (cnt_q == CNT_MAX);

  always_ff @(posedge c20k or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      dt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      dt_q    <= dt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dt_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) state_d = LOW;
      end
      LOW: begin
        if (hi_req) begin
          state_d = DEAD_LH;
          dt_d    = DT;
        end
      end
      DEAD_LH: begin
        dt_d = dt_q - DT_ONE;
        if (!hi_req) state_d = LOW;
        else if (dt_q == DT_ONE) state_d = HIGH;
      end
      HIGH: begin
        if (!hi_req) begin
          state_d = DEAD_HL;
          dt_d    = DT;
        end
      end
      DEAD_HL: begin
        dt_d = dt_q - DT_ONE;
        if (dt_q == DT_ONE) state_d = LOW;
      end
      FAULT: begin
        if (!bus.enable && !bus.fault) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // fault beats disable, disable beats normal sequencing
    if (bus.fault) begin
      state_d = FAULT;
      dt_d    = '0;
    end else if (!bus.enable && state_q != FAULT) begin
      state_d = IDLE;
      dt_d    = '0;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (run_q && run_d) cnt_d = wrap ? '0 : cnt_q + ONE;
  end

`ifdef PWM_SOFT_START_EN
  always_comb begin
    duty_d = duty_q;
    if (!run_d) begin
      duty_d = '0;
    end else if (wrap) begin
      duty_d = (bus.MotorSignal > duty_q) ? duty_q + ONE
                                          : bus.MotorSignal;
    end
  end
`else
  always_comb begin
    duty_d = duty_q;
    if (wrap || state_q == IDLE) duty_d = bus.MotorSignal;
  end
`endif

  always_comb begin
    bus.pwm_hi        = 1'b0;
    bus.pwm_lo        = 1'b0;
    bus.fault_latched = 1'b0;
    bus.period_start  = 1'b0;
    unique case (1'b1)
      (state_q == HIGH):  bus.pwm_hi        = 1'b1;
      (state_q == LOW):   bus.pwm_lo        = 1'b1;
      (state_q == FAULT): bus.fault_latched = 1'b1;
      default: ;
    endcase
    bus.period_start = run_q && (cnt_q == '0);
  end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Downstream stage of the current-control loop. Consumes the 8-bit MotorSignal duty command and produces complementary high-side/low-side gate drive with dead-time insertion.
- Duty is double-buffered and updated only at period boundaries.
- A synchronous fault input forces both gates off until the channel is explicitly re-armed.

Parameters:
- DUTY_WIDTH, 8, width of duty command. PWM period is 2^DUTY_WIDTH-1 clocks (255).
- DEAD_TIME, 2, clocks both gates are held off before either gate turns on (range 1..15).

Ports:
- c20k  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- MotorSignal  input  DUTY_WIDTH  duty command, unsigned, 0 = off, 255 = 100%
- enable  input  1  level; 1 = run PWM, 0 = idle with both gates off
- fault  input  1  level, synchronous; overcurrent/driver fault
- pwm_hi  output  1  high-side gate drive, registered
- pwm_lo  output  1  low-side gate drive, registered
- period_start  output  1  one-cycle pulse in the cycle cnt==0 while running
- fault_latched  output  1  1 while in FAULT state

Behaviour:
- Reset (async): state=IDLE, cnt=0, duty_q=0, dt_cnt=0, all outputs 0.
- Period counter cnt: runs 0..254 and wraps to 0 only in LOW/HIGH/DEAD states. Held at 0 in IDLE/FAULT.
- Duty shadow:
  - duty_q <= MotorSignal on the edge where cnt wraps 254->0.
  - Also loaded every cycle in IDLE.
  - MotorSignal changes mid-period have no effect until the next period.
- hi_req = (cnt < duty_q), combinational. Duty 255 gives hi_req always 1; duty 0 gives hi_req always 0.
- FSM, with outputs decoded from the registered state:
  - IDLE: hi=0, lo=0. enable=1 and fault=0 -> LOW.
  - LOW: lo=1. hi_req -> DEAD_LH, load dt_cnt=DEAD_TIME.
  - DEAD_LH: hi=0, lo=0, dt_cnt decrements.
    - hi_req drops -> LOW (pulse suppressed).
    - dt_cnt reaches 1 with hi_req still 1 -> HIGH.
  - HIGH: hi=1. !hi_req -> DEAD_HL, load dt_cnt.
  - DEAD_HL: hi=0, lo=0 for DEAD_TIME cycles, then -> LOW regardless of hi_req.
  - FAULT: hi=0, lo=0, fault_latched=1. Exits to IDLE only when enable=0 and fault=0 in the same cycle.
- Priority, highest first:
  1. fault=1 in any state -> FAULT next cycle.
  2. enable=0 in any non-FAULT state -> IDLE next cycle.
  3. Normal transitions.
- Timing, steady duty D with DEAD_TIME < D < 255:
  - pwm_hi is high for exactly D-DEAD_TIME cycles per period, starting at cnt=DEAD_TIME+1.
  - pwm_lo falls at cnt=1 and rises at cnt=D+DEAD_TIME+1.
  - Steady D <= DEAD_TIME: pwm_hi never asserts; pwm_lo shows a dead gap each period.
- Invariant: pwm_hi and pwm_lo are never 1 in the same cycle, including across reset, fault, enable toggles and duty changes.
- Reset asserted mid-period: outputs go to 0 immediately (async). Operation restarts from IDLE.

Optional Feature:
- Macro: PWM_SOFT_START_EN
- Defined:
  - At each period boundary, duty_q moves toward MotorSignal by at most +1 per period when increasing.
  - Decreases are applied at once.
  - duty_q is cleared to 0 on entry to IDLE/FAULT and is not loaded from MotorSignal while in IDLE.
- Undefined: duty_q loads MotorSignal directly as described above.

Test Plan (DEAD_TIME=2, macro undefined unless stated):
- Reset asserted mid-HIGH -> pwm_hi/pwm_lo drop to 0 without waiting for a clock edge; state IDLE, cnt 0.
- MotorSignal=100, enable=1 -> each period pwm_hi high for 98 cycles (cnt 3..100); lo low cnt 1..102; period_start every 255 clocks; never both high.
- MotorSignal 0 -> pwm_lo constant 1, pwm_hi 0. MotorSignal 255 -> pwm_hi constant 1 after the first dead-time. MotorSignal 2 -> pwm_hi never 1.
- MotorSignal changed 100->200 at cnt=50 -> current period still ends the pulse at cnt 100; next period pulse covers cnt 3..200.
- fault pulsed 1 cycle during HIGH -> both gates 0 next cycle, fault_latched=1. Stays latched while enable=1. Drop enable -> IDLE. Re-enable -> LOW, PWM resumes.
- PWM_SOFT_START_EN, enable with MotorSignal=10 -> duty_q steps 0,1,2..10 over 10 periods; MotorSignal->3 -> duty_q=3 at the next boundary.
